sram_controller: RTL

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller_pkg.sv | 18 +
 rtl/sram_controller_if.sv | 35 +++
 rtl/sram_controller.sv | 101 ++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the pipeline-to-SRAM bridge: FSM states,
// default timing/base parameters and the external SRAM bus geometry.
package sram_controller_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        WAIT,
        DONE
    } state_e;

    localparam int unsigned WAIT_CYCLES_DEF = 3;
    localparam int unsigned DATA_BASE_DEF   = 1024;
    localparam int unsigned SRAM_ADDR_WIDTH = 18;
    localparam int unsigned SRAM_DATA_WIDTH = 16;

endpackage

// File: rtl/sram_controller_if.sv
// Bundles the memory-stage request/response signals and the 16-bit SRAM pins.
// slave = controller side, master = pipeline plus SRAM device side.
interface sram_controller_if;
    import sram_controller_pkg::*;

    logic                       rd_en;
    logic                       wr_en;
    logic [31:0]                address;
    logic [31:0]                write_data;
    logic [31:0]                read_data;
    logic                       ready;

    logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
    logic [SRAM_DATA_WIDTH-1:0] sram_dq_out;
    logic                       sram_dq_oe;
    logic [SRAM_DATA_WIDTH-1:0] sram_dq_in;
    logic                       sram_we_n;
    logic                       sram_oe_n;
    logic                       sram_ce_n;
    logic                       sram_ub_n;
    logic                       sram_lb_n;

    modport slave (
        input  rd_en, wr_en, address, write_data, sram_dq_in,
        output read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
               sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
    );

    modport master (
        output rd_en, wr_en, address, write_data, sram_dq_in,
        input  read_data, ready, sram_addr, sram_dq_out, sram_dq_oe,
               sram_we_n, sram_oe_n, sram_ce_n, sram_ub_n, sram_lb_n
    );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit pipeline access into two 16-bit SRAM half-word cycles,
// then idles for WAIT_CYCLES before handing ready back to the pipeline.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEF,
    parameter int unsigned DATA_BASE   = DATA_BASE_DEF
) (
    input  logic             clk,
    input  logic             rst,
    sram_controller_if.slave bus
);

    localparam int unsigned          CNT_W    = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_e                     r_state;
    state_e                     w_next_state;
    logic [CNT_W-1:0]           r_wait_cnt;
    logic [SRAM_ADDR_WIDTH-2:0] r_word;
    logic [31:0]                r_wdata;
    logic                       r_is_write;
    logic [31:0]                r_read_data;

    logic                       w_req;
    logic [31:0]                w_offset;
    logic                       w_unused_bits;

    assign w_req         = bus.rd_en | bus.wr_en;
    assign w_offset      = bus.address - DATA_BASE;
    assign w_unused_bits = ^{w_offset[31:SRAM_ADDR_WIDTH+1], w_offset[1:0]};

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (w_req) w_next_state = ACC_LO;
            ACC_LO:  w_next_state = ACC_HI;
            ACC_HI:  w_next_state = (WAIT_CYCLES == 0) ? DONE : WAIT;
            WAIT:    if (r_wait_cnt == CNT_LAST) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves one
    // unassigned; a missed branch would otherwise infer a latch.
    always_comb begin
        bus.ready       = 1'b0;
        bus.sram_addr   = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_we_n   = 1'b1;
        bus.sram_oe_n   = 1'b1;
        unique case (r_state)
            IDLE: bus.ready = ~w_req;
            ACC_LO, ACC_HI: begin
                bus.sram_addr = {r_word, r_state == ACC_HI};
                // Write drives the bus; read enables the SRAM output. Never both.
                if (r_is_write) begin
                    bus.sram_we_n   = 1'b0;
                    bus.sram_dq_oe  = 1'b1;
                    bus.sram_dq_out = (r_state == ACC_HI) ? r_wdata[31:16] : r_wdata[15:0];
                end else begin
                    bus.sram_oe_n   = 1'b0;
                end
            end
            DONE:    bus.ready = 1'b1;
            default: ;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_wait_cnt  <= '0;
            r_word      <= '0;
            r_wdata     <= '0;
            r_is_write  <= 1'b0;
            r_read_data <= '0;
        end else begin
            r_state <= w_next_state;
            // Request is frozen here; later input changes are ignored until IDLE.
            if (r_state == IDLE && w_req) begin
                r_word     <= w_offset[SRAM_ADDR_WIDTH:2];
                r_wdata    <= bus.write_data;
                r_is_write <= bus.wr_en;
            end
            r_wait_cnt <= (r_state == WAIT) ? r_wait_cnt + CNT_W'(1) : '0;
            if (!r_is_write && r_state == ACC_LO) r_read_data[15:0]  <= bus.sram_dq_in;
            if (!r_is_write && r_state == ACC_HI) r_read_data[31:16] <= bus.sram_dq_in;
        end
    end

    assign bus.read_data = r_read_data;
    assign bus.sram_ce_n = 1'b0;
    assign bus.sram_ub_n = 1'b0;
    assign bus.sram_lb_n = 1'b0;

endmodule
